// File: rtl/answer_arbiter.sv
// Round sequencer and first-buzz arbiter for the quiz machine: synchronises host and
// contestant inputs, drives the countdown run/reset lines and latches the winning channel.
module answer_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear,
    input  logic [N-1:0] btn,
    input  logic         time_up,
    output logic         cd_run,
    output logic         cd_rst_n,
    output logic [3:0]   winner,
    output logic [N-1:0] foul,
    output logic [N-1:0] excluded,
    output logic [1:0]   state,
    output logic         alarm
);

    localparam int S = N + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t       st;
    logic [S-1:0] raw;
    logic [S-1:0] sync1;
    logic [S-1:0] sync2;
    logic [S-1:0] prev;
    logic [S-1:0] rise;
    logic [N-1:0] btn_e;
    logic         start_e;
    logic         clear_e;
    logic [N-1:0] eligible;
    logic [3:0]   first_idx;
    logic [N-1:0] win_mask;

    assign raw = {clear, start, btn};

    // Two-flop synchroniser followed by a one-sample history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise     = sync2 & ~prev;
    assign btn_e    = rise[N-1:0];
    assign start_e  = rise[N];
    assign clear_e  = rise[N+1];
    assign eligible = btn_e & ~excluded;

    // Descending scan so the lowest eligible channel wins a tie.
    always_comb begin
        first_idx = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) first_idx = 4'(i + 1);
        end
    end

    always_comb begin
        win_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == 4'(i + 1)) win_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            winner   <= 4'd0;
            foul     <= '0;
            excluded <= '0;
            cd_run   <= 1'b0;
            cd_rst_n <= 1'b0;
            alarm    <= 1'b0;
        end else if (clear_e) begin
            st       <= IDLE;
            winner   <= 4'd0;
            foul     <= '0;
            excluded <= '0;
            cd_run   <= 1'b0;
            cd_rst_n <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    foul     <= foul | btn_e;
                    excluded <= excluded | btn_e;
                    if (start_e) begin
                        st       <= COUNT;
                        cd_rst_n <= 1'b1;
                        cd_run   <= 1'b1;
                    end
                end
                COUNT: begin
                    if (|eligible) begin
                        st     <= LOCKED;
                        winner <= first_idx;
                        cd_run <= 1'b0;
                    end else if (time_up || (&excluded)) begin
                        st     <= TIMEOUT;
                        cd_run <= 1'b0;
                        alarm  <= 1'b1;
                    end
                end
                LOCKED: begin
                    // Wrong answer: bar this contestant and resume the paused countdown.
                    if (start_e) begin
                        excluded <= excluded | win_mask;
                        winner   <= 4'd0;
                        st       <= COUNT;
                        cd_run   <= 1'b1;
                    end
                end
                TIMEOUT: begin
                    cd_run <= 1'b0;
                    alarm  <= 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_answer_arbiter.sv
// Bench for answer_arbiter: directed round scenarios plus random traffic, each cycle
// scored against a behavioural model of the round rules.
module tb_answer_arbiter;

    localparam int N    = 4;
    localparam int W    = 2 + 4 + N + N + 3;
    localparam int MAXC = 8000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         clear;
    logic [N-1:0] btn;
    logic         time_up;
    logic         cd_run;
    logic         cd_rst_n;
    logic [3:0]   winner;
    logic [N-1:0] foul;
    logic [N-1:0] excluded;
    logic [1:0]   state;
    logic         alarm;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    answer_arbiter #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear    (clear),
        .btn      (btn),
        .time_up  (time_up),
        .cd_run   (cd_run),
        .cd_rst_n (cd_rst_n),
        .winner   (winner),
        .foul     (foul),
        .excluded (excluded),
        .state    (state),
        .alarm    (alarm)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs are remembered per cycle; an input edge takes effect two cycles later.
    logic [N+1:0] hist[MAXC];
    int           cyc      = 0;
    int           last_rst = 0;
    int           m_state;
    int           m_winner;
    logic [N-1:0] m_foul;
    logic [N-1:0] m_excl;
    bit           m_run;
    bit           m_rstn;
    bit           m_alarm;

    function automatic logic [N+1:0] hin(input int x);
        if (x < 0 || x <= last_rst || x >= MAXC) return '0;
        return hist[x];
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_winner = 0;
        m_foul   = '0;
        m_excl   = '0;
        m_run    = 1'b0;
        m_rstn   = 1'b0;
        m_alarm  = 1'b0;
    endtask

    task automatic model_step(input bit tu);
        logic [N+1:0] r;
        logic [N-1:0] be;
        logic [N-1:0] elig;
        bit           se;
        bit           ce;
        r  = hin(cyc - 2) & ~hin(cyc - 3);
        be = r[N-1:0];
        se = r[N];
        ce = r[N+1];
        if (ce) begin
            model_reset();
        end else begin
            case (m_state)
                0: begin
                    m_foul = m_foul | be;
                    m_excl = m_excl | be;
                    if (se) begin
                        m_state = 1;
                        m_rstn  = 1'b1;
                        m_run   = 1'b1;
                    end
                end
                1: begin
                    elig = be & ~m_excl;
                    if (elig != '0) begin
                        for (int i = 0; i < N; i++) begin
                            if (elig[i]) begin
                                m_winner = i + 1;
                                break;
                            end
                        end
                        m_state = 2;
                        m_run   = 1'b0;
                    end else if (tu || m_excl == {N{1'b1}}) begin
                        m_state = 3;
                        m_run   = 1'b0;
                        m_alarm = 1'b1;
                    end
                end
                2: begin
                    if (se) begin
                        m_excl[m_winner-1] = 1'b1;
                        m_winner = 0;
                        m_state  = 1;
                        m_run    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (cyc < MAXC) hist[cyc] = {clear, start, btn};
            if (!rst_n) begin
                last_rst = cyc;
                model_reset();
            end else begin
                model_step(time_up);
            end
            exp_q.push_back({2'(m_state), 4'(m_winner), m_foul, m_excl, m_run, m_rstn, m_alarm});
            cyc++;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("exp_q_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_state",    state,    e[W-1 -: 2]);
                chk("sb_winner",   winner,   e[W-3 -: 4]);
                chk("sb_foul",     foul,     e[W-7 -: N]);
                chk("sb_excluded", excluded, e[W-7-N -: N]);
                chk("sb_cd_run",   cd_run,   e[2]);
                chk("sb_cd_rst_n", cd_rst_n, e[1]);
                chk("sb_alarm",    alarm,    e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(3);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(3);
        clear = 1'b0;
        tick(2);
    endtask

    // Reset dropped between clock edges must take effect without waiting for clk.
    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state",    state,    0);
        chk("async_rst_winner",   winner,   0);
        chk("async_rst_foul",     foul,     0);
        chk("async_rst_excluded", excluded, 0);
        chk("async_rst_cd_run",   cd_run,   0);
        chk("async_rst_cd_rst_n", cd_rst_n, 0);
        chk("async_rst_alarm",    alarm,    0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        clear   = 1'b0;
        btn     = '0;
        time_up = 1'b0;
        tick(3);
        chk("reset_state", state, 0);
        chk("reset_cd_rst_n", cd_rst_n, 0);
        rst_n = 1'b1;
        tick(2);

        // arm and single buzz
        start = 1'b1;
        tick(3);
        chk("arm_state", state, 1);
        chk("arm_cd_run", cd_run, 1);
        chk("arm_cd_rst_n", cd_rst_n, 1);
        start = 1'b0;
        btn = 4'b0100;
        tick(3);
        chk("buzz_state", state, 2);
        chk("buzz_winner", winner, 3);
        chk("buzz_cd_run", cd_run, 0);
        btn = '0;
        pulse_clear();

        // simultaneous buzz resolves low, later buzz ignored
        pulse_start();
        btn = 4'b1010;
        tick(3);
        chk("tie_winner", winner, 2);
        btn = '0;
        tick(2);
        btn = 4'b0001;
        tick(3);
        chk("locked_ignore_winner", winner, 2);
        btn = '0;
        pulse_clear();

        // early press fouls and excludes
        btn = 4'b0010;
        tick(3);
        btn = '0;
        tick(1);
        pulse_start();
        btn = 4'b0010;
        tick(3);
        chk("excluded_press_state", state, 1);
        btn = 4'b0000;
        tick(1);
        btn = 4'b1000;
        tick(3);
        chk("foul_winner", winner, 4);
        chk("foul_flags", foul, 4'b0010);
        btn = '0;
        pulse_clear();

        // wrong answer resumes the round with the winner barred
        pulse_start();
        btn = 4'b0001;
        tick(3);
        chk("wrong_first_winner", winner, 1);
        btn = '0;
        tick(1);
        start = 1'b1;
        tick(3);
        chk("wrong_excluded", excluded, 4'b0001);
        chk("wrong_winner", winner, 0);
        chk("wrong_state", state, 1);
        chk("wrong_cd_run", cd_run, 1);
        chk("wrong_cd_rst_n", cd_rst_n, 1);
        start = 1'b0;
        btn = 4'b0001;
        tick(3);
        chk("barred_press_state", state, 1);
        btn = '0;
        pulse_clear();

        // timeout, ignored buzz, clear
        pulse_start();
        time_up = 1'b1;
        tick(1);
        chk("timeout_state", state, 3);
        chk("timeout_alarm", alarm, 1);
        chk("timeout_winner", winner, 0);
        time_up = 1'b0;
        btn = 4'b0100;
        tick(3);
        chk("timeout_btn_state", state, 3);
        btn = '0;
        clear = 1'b1;
        tick(3);
        chk("clear_state", state, 0);
        chk("clear_alarm", alarm, 0);
        chk("clear_cd_rst_n", cd_rst_n, 0);
        clear = 1'b0;
        tick(2);

        // buzz beats time_up in the same cycle
        pulse_start();
        btn = 4'b0100;
        tick(2);
        time_up = 1'b1;
        tick(1);
        chk("race_state", state, 2);
        chk("race_winner", winner, 3);
        chk("race_alarm", alarm, 0);
        time_up = 1'b0;
        btn = '0;
        pulse_clear();

        // asynchronous reset in the middle of a round
        pulse_start();
        reset_mid();
        tick(2);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
            end
            if ($urandom_range(0, 9) == 0) start = ~start;
            if (clear) begin
                if ($urandom_range(0, 2) == 0) clear = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                clear = 1'b1;
            end
            time_up = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 799) == 0) reset_mid();
            else tick(1);
        end

        btn     = '0;
        start   = 1'b0;
        clear   = 1'b0;
        time_up = 1'b0;
        tick(3);
        #2;
        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
